fetch_sequencer: RTL

- Instruction-fetch controller that owns the program counter and sequences instruction-memory accesses for the IF stage.
- Holds one fetched instruction in an output buffer for the IF/ID boundary and honours hazard-unit stalls.
- Applies branch/jump redirects, exception entry and eret, with priority: exception over eret over redirect.
- Sits between the hazard/branch logic in ID, the CP0 exception logic, and the instruction memory.

---
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one instruction-memory
// request at a time, buffers the fetched word for IF/ID and applies
// exception, eret and branch/jump redirects.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_adel,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] req_addr_reg, req_addr_next;
  logic        kill_reg, kill_next;
  logic        pend_valid_reg, pend_valid_next;
  logic [31:0] pend_pc_reg, pend_pc_next;
  logic        if_valid_reg, if_valid_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic [31:0] if_instr_reg, if_instr_next;
  logic        if_adel_reg, if_adel_next;

  logic        flush;
  logic [31:0] flush_target;
  logic        misaligned;
  logic        in_fetch;
  logic        resp;
  logic        accept;
  logic        redir_take;

  // Exception outranks eret; a misaligned address completes without a bus access.
  assign flush        = exc_req | eret_req;
  assign flush_target = exc_req ? EXC_PC : epc;
  assign misaligned   = |req_addr_reg[1:0];
  assign in_fetch     = (state_reg == FETCH);
  assign resp         = in_fetch && (misaligned || imem_ready);
  assign accept       = resp && !kill_reg && !flush;
  assign redir_take   = redirect_valid && !stall;

  assign imem_req  = in_fetch && !misaligned;
  assign imem_addr = req_addr_reg;
  assign if_valid  = if_valid_reg;
  assign if_pc     = if_pc_reg;
  assign if_instr  = if_instr_reg;
  assign if_adel   = if_adel_reg;
  assign pc        = pc_reg;

  // State register with immediate (asynchronous) reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      req_addr_reg   <= RESET_PC;
      kill_reg       <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_pc_reg    <= 32'd0;
      if_valid_reg   <= 1'b0;
      if_pc_reg      <= 32'd0;
      if_instr_reg   <= 32'd0;
      if_adel_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      req_addr_reg   <= req_addr_next;
      kill_reg       <= kill_next;
      pend_valid_reg <= pend_valid_next;
      pend_pc_reg    <= pend_pc_next;
      if_valid_reg   <= if_valid_next;
      if_pc_reg      <= if_pc_next;
      if_instr_reg   <= if_instr_next;
      if_adel_reg    <= if_adel_next;
    end
  end

  // Next-state logic: flush first, then the normal fetch/hold sequence.
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    req_addr_next   = req_addr_reg;
    kill_next       = kill_reg;
    pend_valid_next = pend_valid_reg;
    pend_pc_next    = pend_pc_reg;
    if_valid_next   = if_valid_reg;
    if_pc_next      = if_pc_reg;
    if_instr_next   = if_instr_reg;
    if_adel_next    = if_adel_reg;

    if (flush) begin
      pc_next         = flush_target;
      pend_valid_next = 1'b0;
      if_valid_next   = 1'b0;
      if (!in_fetch || resp) begin
        // Nothing outstanding (or it just finished): restart at the target now.
        state_next    = FETCH;
        req_addr_next = flush_target;
        kill_next     = 1'b0;
      end else begin
        // Request still in flight: let it finish at its address, then drop it.
        kill_next = 1'b1;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          state_next    = FETCH;
          req_addr_next = pc_reg;
        end
        FETCH: begin
          if (resp && kill_reg) begin
            kill_next     = 1'b0;
            req_addr_next = pc_reg;
          end else if (accept) begin
            if_valid_next   = 1'b1;
            if_pc_next      = req_addr_reg;
            if_instr_next   = misaligned ? 32'd0 : imem_rdata;
            if_adel_next    = misaligned;
            pend_valid_next = 1'b0;
            if (redir_take)
              pc_next = redirect_pc;
            else if (pend_valid_reg)
              pc_next = pend_pc_reg;
            else
              pc_next = req_addr_reg + 32'd4;
            state_next = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_valid_next = 1'b0;
            req_addr_next = pc_reg;
            state_next    = FETCH;
          end
        end
        default: state_next = IDLE;
      endcase
      // A redirect not consumed by this cycle's response waits for the next one.
      if (redir_take && !accept) begin
        pend_valid_next = 1'b1;
        pend_pc_next    = redirect_pc;
      end
    end
  end

endmodule
